// File: rtl/hop_latency_checker_if.sv
// Boundary bundle between the hop-latency checker and the flop chain it drives and captures.
// The checker takes the slave view. The chain and run-control side takes the master view.
interface hop_latency_checker_if #(
    parameter int CNT_W = 4
);
    logic             go;
    logic             ff_in;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       err_count;
    logic [CNT_W-1:0] last_lat;

    modport master (
        output go, ff_in,
        input  start, busy, done, pass, err_count, last_lat
    );

    modport slave (
        input  go, ff_in,
        output start, busy, done, pass, err_count, last_lat
    );
endinterface

// File: rtl/hop_latency_checker.sv
// Launches single-cycle pulses into a flop chain and times each echo against EXP_LAT.
// After NUM_TRIALS trials, or after a stuck-high abort, it reports the run's pass/fail.
module hop_latency_checker #(
    parameter int EXP_LAT    = 4,
    parameter int TIMEOUT    = 15,
    parameter int NUM_TRIALS = 8,
    parameter int CNT_W      = 4
) (
    input logic                  clock0,
    input logic                  rst1,
    hop_latency_checker_if.slave bus
);
    localparam int TRIAL_W = $clog2(NUM_TRIALS + 1);

    localparam logic [CNT_W-1:0]   EXP_LAT_C    = CNT_W'(EXP_LAT);
    localparam logic [CNT_W-1:0]   TIMEOUT_C    = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
    localparam logic [TRIAL_W-1:0] NUM_TRIALS_C = TRIAL_W'(NUM_TRIALS);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        GAP,
        DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [TRIAL_W-1:0] trial;
    logic [TRIAL_W-1:0] trial_nxt;
    logic               start_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic [3:0]         err_q;
    logic [CNT_W-1:0]   lat_q;

    assign trial_nxt = trial + 1'b1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // In WAIT, cnt is the number of cycles since launch. In GAP, cnt is the number of consecutive high echo cycles.
    // In both states it stops at TIMEOUT, so it can never wrap.
    // NOTE: every state register below is assigned with <= so that each branch sees pre-edge values regardless of statement order.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            state   <= IDLE;
            cnt     <= '0;
            trial   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 4'd0;
            lat_q   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.go) begin
                        state   <= LAUNCH;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= 4'd0;
                        trial   <= '0;
                        cnt     <= '0;
                    end
                end

                LAUNCH: begin
                    start_q <= 1'b0;
                    cnt     <= CNT_ONE;
                    state   <= WAIT;
                end

                WAIT: begin
                    if (bus.ff_in) begin
                        lat_q <= cnt;
                        if (cnt != EXP_LAT_C) begin
                            err_q <= sat_inc(err_q);
                        end
                        cnt   <= CNT_ONE;
                        state <= GAP;
                    end else if (cnt == TIMEOUT_C) begin
                        lat_q <= TIMEOUT_C;
                        err_q <= sat_inc(err_q);
                        cnt   <= CNT_ONE;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (!bus.ff_in) begin
                        trial <= trial_nxt;
                        if (trial_nxt == NUM_TRIALS_C) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            pass_q <= (err_q == 4'd0);
                        end else begin
                            state   <= LAUNCH;
                            start_q <= 1'b1;
                        end
                    end else if (cnt == TIMEOUT_C) begin
                        // The echo is stuck high, so no further trial can be measured and the run is aborted.
                        err_q  <= sat_inc(err_q);
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.start     = start_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.last_lat  = lat_q;
endmodule

// File: tb/tb_hop_latency_checker.sv
// Bench for hop_latency_checker: a configurable chain model drives the echo input.
// A time-flow reference model predicts every output on every cycle.
module tb_hop_latency_checker;
    localparam int EXP_LAT    = 4;
    localparam int TIMEOUT    = 15;
    localparam int NUM_TRIALS = 8;
    localparam int CNT_W      = 4;

    logic clock0 = 1'b0;
    logic rst1;
    always #5 clock0 = ~clock0;

    hop_latency_checker_if #(.CNT_W(CNT_W)) bus ();

    hop_latency_checker #(
        .EXP_LAT(EXP_LAT), .TIMEOUT(TIMEOUT), .NUM_TRIALS(NUM_TRIALS), .CNT_W(CNT_W)
    ) dut (
        .clock0 (clock0),
        .rst1   (rst1),
        .bus    (bus.slave)
    );

    // Chain model. Mode 0 is start delayed by tap+1 cycles, 1 ties the echo low, 2 ties it high, and 3 is random noise.
    int         mode = 1;
    logic [2:0] tap  = 3'd3;
    logic [7:0] hist = '0;
    logic       rnd_bit = 1'b0;
    logic       ff;

    always @(posedge clock0) hist <= {hist[6:0], bus.start};
    always @(negedge clock0) rnd_bit <= ($urandom_range(0, 3) == 0);

    always_comb begin
        case (mode)
            0:       ff = hist[tap];
            1:       ff = 1'b0;
            2:       ff = 1'b1;
            default: ff = rnd_bit;
        endcase
    end
    assign bus.ff_in = ff;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model. It follows a run as straight-line code over time, and each exp_* value holds what the outputs must show during the current cycle.
    bit exp_start, exp_busy, exp_done, exp_pass;
    int exp_err, exp_lat;

    task automatic model_edge(output bit hit);
        @(posedge clock0 or posedge rst1);
        hit = rst1;
    endtask

    task automatic clear_exp();
        exp_start = 0; exp_busy = 0; exp_done = 0; exp_pass = 0;
        exp_err = 0;   exp_lat = 0;
    endtask

    task automatic finish_run();
        exp_start = 0; exp_busy = 0; exp_done = 1; exp_pass = (exp_err == 0);
    endtask

    task automatic run_model(output bit rh);
        bit r;
        bit echoed;
        int n;
        int highs;
        rh = 0;
        exp_err = 0; exp_done = 0; exp_pass = 0; exp_busy = 1;
        for (int t = 0; t < NUM_TRIALS; t++) begin
            exp_start = 1;
            model_edge(r); if (r) begin rh = 1; return; end
            exp_start = 0;
            n = 0; echoed = 0;
            while (!echoed && n < TIMEOUT) begin
                n++;
                model_edge(r); if (r) begin rh = 1; return; end
                echoed = bus.ff_in;
            end
            exp_lat = n;
            if (!echoed || n != EXP_LAT) exp_err = (exp_err < 15) ? exp_err + 1 : 15;
            highs = 0;
            forever begin
                model_edge(r); if (r) begin rh = 1; return; end
                if (!bus.ff_in) break;
                highs++;
                if (highs == TIMEOUT) begin
                    exp_err = (exp_err < 15) ? exp_err + 1 : 15;
                    finish_run();
                    return;
                end
            end
        end
        finish_run();
    endtask

    initial begin : model
        bit r;
        bit rh;
        clear_exp();
        forever begin
            model_edge(r);
            if (r) begin
                clear_exp();
            end else if (bus.go) begin
                run_model(rh);
                if (rh) clear_exp();
            end
        end
    end

    bit checking = 0;
    always @(negedge clock0) begin
        if (checking) begin
            check("start",     int'(bus.start),     int'(exp_start));
            check("busy",      int'(bus.busy),      int'(exp_busy));
            check("done",      int'(bus.done),      int'(exp_done));
            check("pass",      int'(bus.pass),      int'(exp_pass));
            check("err_count", int'(bus.err_count), exp_err);
            check("last_lat",  int'(bus.last_lat),  exp_lat);
        end
    end

    int pulses = 0;
    always @(posedge clock0) if (bus.start === 1'b1) pulses++;

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Pulse go and count the cycles from the first launch until done rises.
    task automatic run_timed(input int budget, output int cyc);
        @(negedge clock0); bus.go = 1'b1;
        @(negedge clock0); bus.go = 1'b0;
        check("launch_start", int'(bus.start), 1);
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < budget) begin
            @(negedge clock0);
            cyc++;
        end
        check("done_reached", int'(bus.done === 1'b1), 1);
    endtask

    int cyc, base, seen, k;

    initial begin : stim
        rst1 = 1'b1;
        bus.go = 1'b0;
        repeat (2) @(negedge clock0);
        checking = 1;
        check("rst_start", int'(bus.start), 0);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_err",   int'(bus.err_count), 0);
        check("rst_lat",   int'(bus.last_lat), 0);
        @(negedge clock0); rst1 = 1'b0;
        repeat (3) @(negedge clock0);

        // Correct 4-flop chain.
        mode = 0; tap = 3'd3; base = pulses;
        run_timed(200, cyc);
        check("c4_cycles", cyc, 48);
        check("c4_lat",    int'(bus.last_lat), 4);
        check("c4_err",    int'(bus.err_count), 0);
        check("c4_pass",   int'(bus.pass), 1);
        check("c4_pulses", pulses - base, 8);

        // Short 3-flop chain.
        tap = 3'd2;
        run_timed(200, cyc);
        check("c3_cycles", cyc, 40);
        check("c3_lat",    int'(bus.last_lat), 3);
        check("c3_err",    int'(bus.err_count), 8);
        check("c3_pass",   int'(bus.pass), 0);

        // Open chain, where every trial times out.
        mode = 1;
        run_timed(400, cyc);
        check("open_cycles", cyc, 136);
        check("open_lat",    int'(bus.last_lat), 15);
        check("open_err",    int'(bus.err_count), 8);
        check("open_pass",   int'(bus.pass), 0);

        // Stuck-high chain, where the run aborts after one launch.
        mode = 2; base = pulses;
        run_timed(100, cyc);
        check("stuck_cycles", cyc, 17);
        check("stuck_lat",    int'(bus.last_lat), 1);
        check("stuck_err",    int'(bus.err_count), 2);
        check("stuck_pass",   int'(bus.pass), 0);
        check("stuck_pulses", pulses - base, 1);

        // Asynchronous reset during the WAIT phase of trial 3.
        mode = 0; tap = 3'd2;
        @(negedge clock0); bus.go = 1'b1;
        @(negedge clock0); bus.go = 1'b0;
        seen = (bus.start === 1'b1) ? 1 : 0;
        k = 0;
        while (seen < 3 && k < 100) begin
            @(negedge clock0);
            k++;
            if (bus.start === 1'b1) seen++;
        end
        check("t3_launch", seen, 3);
        check("t3_err",    int'(bus.err_count), 2);
        check("t3_lat",    int'(bus.last_lat), 3);
        check("t3_busy",   int'(bus.busy), 1);
        @(posedge clock0); #2 rst1 = 1'b1;
        #1;
        check("arst_start", int'(bus.start), 0);
        check("arst_busy",  int'(bus.busy), 0);
        check("arst_err",   int'(bus.err_count), 0);
        check("arst_lat",   int'(bus.last_lat), 0);
        repeat (2) @(negedge clock0);
        rst1 = 1'b0;
        base = pulses;
        repeat (10) @(negedge clock0);
        check("idle_pulses", pulses - base, 0);
        check("idle_busy",   int'(bus.busy), 0);

        // Asynchronous reset inside a LAUNCH cycle drops start at once.
        @(negedge clock0); bus.go = 1'b1;
        @(negedge clock0); bus.go = 1'b0;
        check("l_start_hi", int'(bus.start), 1);
        #2 rst1 = 1'b1;
        #1;
        check("l_start_lo", int'(bus.start), 0);
        @(negedge clock0); rst1 = 1'b0;
        repeat (2) @(negedge clock0);

        // go held through a whole run, so the next run starts right after DONE.
        tap = 3'd3;
        @(negedge clock0); bus.go = 1'b1;
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clock0);
            k++;
        end
        check("held_done",   int'(bus.done === 1'b1), 1);
        check("held_cycles", k, 49);
        check("held_err",    int'(bus.err_count), 0);
        @(negedge clock0);
        check("rerun_done",  int'(bus.done), 0);
        check("rerun_start", int'(bus.start), 1);
        check("rerun_busy",  int'(bus.busy), 1);
        bus.go = 1'b0;
        k = 0;
        while (bus.done !== 1'b1 && k < 100) begin
            @(negedge clock0);
            k++;
        end
        check("rerun_finish", int'(bus.done === 1'b1), 1);
        check("rerun_pass",   int'(bus.pass), 1);

        // Randomised chains and go traffic, checked every cycle by the model.
        for (int ph = 0; ph < 8; ph++) begin
            mode = int'($urandom_range(0, 3));
            tap  = 3'($urandom_range(0, 7));
            for (int c = 0; c < 150; c++) begin
                @(negedge clock0);
                bus.go = ($urandom_range(0, 15) == 0);
            end
        end
        @(negedge clock0); bus.go = 1'b0;
        repeat (200) @(negedge clock0);

        checking = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
